// File: rtl/bsg_gateway_clk_div_if.sv
// ---------------------------------------------------------------------------
// bsg_gateway_clk_div_if
//   Configuration write channel of the gateway clock divider.
//   master : the configuration source (drives valid + payload)
//   slave  : the divider (drives ready + error pulse)
//   Signals:
//     cfg_v_i      write valid
//     cfg_ready_o  divider can accept a write
//     cfg_chan_i   target channel
//     cfg_div_i    divide ratio D
//     cfg_phase_i  start phase P (used on sync)
//     cfg_en_i     channel enable
//     cfg_err_o    one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
interface bsg_gateway_clk_div_if #(
  parameter int num_clk_p   = 4,
  parameter int div_width_p = 8
);
  localparam int lg_p = (num_clk_p > 1) ? $clog2(num_clk_p) : 1;

  logic                   cfg_v_i;
  logic                   cfg_ready_o;
  logic [lg_p-1:0]        cfg_chan_i;
  logic [div_width_p-1:0] cfg_div_i;
  logic [div_width_p-1:0] cfg_phase_i;
  logic                   cfg_en_i;
  logic                   cfg_err_o;

  modport master (
    output cfg_v_i, cfg_chan_i, cfg_div_i, cfg_phase_i, cfg_en_i,
    input  cfg_ready_o, cfg_err_o
  );

  modport slave (
    input  cfg_v_i, cfg_chan_i, cfg_div_i, cfg_phase_i, cfg_en_i,
    output cfg_ready_o, cfg_err_o
  );
endinterface

// File: rtl/bsg_gateway_clk_div.sv
// ---------------------------------------------------------------------------
// bsg_gateway_clk_div
//   Runtime-programmable multi-channel clock divider. Each channel counts
//   0..D-1 and drives its output high while cnt < floor(D/2). New settings
//   for a running channel wait for the end of its current period, so no
//   runt pulse is produced. sync_i realigns every enabled channel to its
//   programmed start phase. locked_o reports that nothing has been
//   reprogrammed or resynced for lock_cycles_p edges.
//
//   Ports:
//     clk_i      reference clock (only clock)
//     reset_n_i  asynchronous active-low reset
//     cfg_if     configuration write channel (slave side)
//     sync_i     realign all enabled channels
//     gate_n_i   per-channel gate, active low (only with
//                BSG_GATEWAY_CLK_DIV_GATE_EN defined)
//     clk_o      divided clocks, each straight from a flop
//     locked_o   outputs settled
//
//   Optional feature macro: BSG_GATEWAY_CLK_DIV_GATE_EN
// ---------------------------------------------------------------------------
module bsg_gateway_clk_div #(
  parameter int num_clk_p     = 4,
  parameter int div_width_p   = 8,
  parameter int lock_cycles_p = 256
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_gateway_clk_div_if.slave cfg_if,
  input  logic                 sync_i,
`ifdef BSG_GATEWAY_CLK_DIV_GATE_EN
  input  logic [num_clk_p-1:0] gate_n_i,
`endif
  output logic [num_clk_p-1:0] clk_o,
  output logic                 locked_o
);

  localparam int lg_p      = (num_clk_p > 1) ? $clog2(num_clk_p) : 1;
  localparam int lock_w_lp = $clog2(lock_cycles_p + 1);

  localparam logic [lg_p:0]            chan_lim_lp = (lg_p + 1)'(num_clk_p);
  localparam logic [lock_w_lp-1:0]     lock_max_lp = lock_w_lp'(lock_cycles_p);
  localparam logic [lock_w_lp-1:0]     lock_one_lp = lock_w_lp'(1);
  localparam logic [div_width_p-1:0]   one_lp      = div_width_p'(1);
  localparam logic [div_width_p-1:0]   two_lp      = div_width_p'(2);

  // per-channel live configuration and counters
  logic [num_clk_p-1:0]                  en_q, en_d;
  logic [num_clk_p-1:0][div_width_p-1:0] div_q, div_d;
  logic [num_clk_p-1:0][div_width_p-1:0] ph_q, ph_d;
  logic [num_clk_p-1:0][div_width_p-1:0] cnt_q, cnt_d;
  logic [num_clk_p-1:0]                  clk_q, clk_d;
  logic [num_clk_p-1:0]                  gated_q, gated_d;

  // a single pending slot is enough: ready drops while it is occupied
  logic                   pend_q, pend_d;
  logic [lg_p-1:0]        pend_chan_q, pend_chan_d;
  logic [div_width_p-1:0] pend_div_q, pend_div_d;
  logic [div_width_p-1:0] pend_ph_q, pend_ph_d;
  logic                   pend_en_q, pend_en_d;

  logic                   err_q, err_d;
  logic [lock_w_lp-1:0]   lock_q, lock_d;
  logic                   locked_q, locked_d;

  logic                   ready_s, accept_s, cfg_ok_s, wr_s, to_pend_s, applied_s;
  logic [num_clk_p-1:0]   boundary_s, gate_s, wr_tgt_s, wr_load_s, pend_hit_s, restart_s;

  // a write is legal only for an existing channel with D >= 2 and P < D
  function automatic logic cfg_legal(input logic [div_width_p-1:0] div,
                                     input logic [div_width_p-1:0] ph,
                                     input logic [lg_p-1:0]        chan);
    return (div >= two_lp) && (ph < div) && ({1'b0, chan} < chan_lim_lp);
  endfunction

`ifdef BSG_GATEWAY_CLK_DIV_GATE_EN
  assign gate_s = ~gate_n_i;
`else
  assign gate_s = '0;
`endif

  assign ready_s            = ~pend_q;
  assign cfg_if.cfg_ready_o = ready_s;
  assign cfg_if.cfg_err_o   = err_q;
  assign clk_o              = clk_q;
  assign locked_o           = locked_q;

  assign accept_s = cfg_if.cfg_v_i & ready_s;
  assign cfg_ok_s = cfg_legal(cfg_if.cfg_div_i, cfg_if.cfg_phase_i, cfg_if.cfg_chan_i);
  assign wr_s     = accept_s & cfg_ok_s;
  assign err_d    = accept_s & ~cfg_ok_s;

  // per-channel event decode: period end, write target, pending release
  always_comb begin
    boundary_s = '0;
    wr_tgt_s   = '0;
    pend_hit_s = '0;
    for (int c = 0; c < num_clk_p; c++) begin
      boundary_s[c] = en_q[c] & (cnt_q[c] == (div_q[c] - one_lp));
      wr_tgt_s[c]   = wr_s & (cfg_if.cfg_chan_i == lg_p'(c));
      pend_hit_s[c] = pend_q & (pend_chan_q == lg_p'(c)) & (boundary_s[c] | sync_i);
    end
  end

  // idle channels and same-edge sync take the write at once; running ones defer it
  assign wr_load_s = wr_tgt_s & (~en_q | {num_clk_p{sync_i}});
  assign to_pend_s = (|(wr_tgt_s & en_q)) & ~sync_i;
  assign applied_s = (|pend_hit_s) | (|wr_load_s);
  // gate state is only resampled where a new period starts
  assign restart_s = pend_hit_s | wr_load_s | boundary_s | ~en_q | {num_clk_p{sync_i}};

  // channel next-state: config load, counter step/realign, output level
  always_comb begin
    en_d    = en_q;
    div_d   = div_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    gated_d = gated_q;
    clk_d   = '0;
    for (int c = 0; c < num_clk_p; c++) begin
      if (pend_hit_s[c]) begin
        en_d[c]  = pend_en_q;
        div_d[c] = pend_div_q;
        ph_d[c]  = pend_ph_q;
      end else if (wr_load_s[c]) begin
        en_d[c]  = cfg_if.cfg_en_i;
        div_d[c] = cfg_if.cfg_div_i;
        ph_d[c]  = cfg_if.cfg_phase_i;
      end else begin
        en_d[c]  = en_q[c];
        div_d[c] = div_q[c];
        ph_d[c]  = ph_q[c];
      end

      if (restart_s[c]) begin
        gated_d[c] = gate_s[c];
      end else begin
        gated_d[c] = gated_q[c];
      end

      // sync overrides both a boundary wrap and a fresh load
      if (sync_i & en_d[c]) begin
        cnt_d[c] = ph_d[c];
      end else if (pend_hit_s[c] | wr_load_s[c] | boundary_s[c] | ~en_q[c]) begin
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + one_lp;
      end

      clk_d[c] = en_d[c] & ~gated_d[c] & (cnt_d[c] < {1'b0, div_d[c][div_width_p-1:1]});
    end
  end

  // pending slot: filled by a write to a running channel, drained when applied
  always_comb begin
    pend_d      = pend_q;
    pend_chan_d = pend_chan_q;
    pend_div_d  = pend_div_q;
    pend_ph_d   = pend_ph_q;
    pend_en_d   = pend_en_q;
    if (|pend_hit_s) begin
      pend_d = 1'b0;
    end else if (to_pend_s) begin
      pend_d      = 1'b1;
      pend_chan_d = cfg_if.cfg_chan_i;
      pend_div_d  = cfg_if.cfg_div_i;
      pend_ph_d   = cfg_if.cfg_phase_i;
      pend_en_d   = cfg_if.cfg_en_i;
    end else begin
      pend_d = pend_q;
    end
  end

  // settle counter: restarts on any applied config or sync, saturates at the target
  always_comb begin
    if (applied_s | sync_i) begin
      lock_d = '0;
    end else if (lock_q == lock_max_lp) begin
      lock_d = lock_q;
    end else begin
      lock_d = lock_q + lock_one_lp;
    end
    // registered form of (counter == target) & ready, using next-state values
    locked_d = (lock_d == lock_max_lp) & ~pend_d;
  end

  // state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q        <= '0;
      div_q       <= '0;
      ph_q        <= '0;
      cnt_q       <= '0;
      clk_q       <= '0;
      gated_q     <= '0;
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      pend_div_q  <= '0;
      pend_ph_q   <= '0;
      pend_en_q   <= 1'b0;
      err_q       <= 1'b0;
      lock_q      <= '0;
      locked_q    <= 1'b0;
    end else begin
      en_q        <= en_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      gated_q     <= gated_d;
      pend_q      <= pend_d;
      pend_chan_q <= pend_chan_d;
      pend_div_q  <= pend_div_d;
      pend_ph_q   <= pend_ph_d;
      pend_en_q   <= pend_en_d;
      err_q       <= err_d;
      lock_q      <= lock_d;
      locked_q    <= locked_d;
    end
  end

endmodule
